// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the ML-DSA NTT datapath.
// The optional inverse mode is enabled with the macro NTT_ADDR_GEN_INTT_EN.
package ntt_pkg;

   localparam int unsigned Q       = 8380417;
   localparam int unsigned N       = 256;
   localparam int unsigned LAYERS  = 8;
   localparam int unsigned COEFF_W = 23;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ntt_idx_calc.sv
// Combinational butterfly index map: (layer, butterfly[, inv]) -> (j, j+len, zeta index k).
// The inverse (Gentleman-Sande) mapping exists only when NTT_ADDR_GEN_INTT_EN is defined.
module ntt_idx_calc
   import ntt_pkg::*;
#(
   parameter int AW = 8
) (
   input  logic [$clog2(AW)-1:0] i_layer,
   input  logic [AW-2:0]         i_bf,
`ifdef NTT_ADDR_GEN_INTT_EN
   input  logic                  i_inv,
`endif
   output logic [AW-1:0]         o_j,
   output logic [AW-1:0]         o_jl,
   output logic [AW-1:0]         o_k
);

   localparam int LW = $clog2(AW);
   localparam logic [AW-1:0] ONE   = AW'(1);
   localparam logic [AW-1:0] HALF  = ONE << (AW - 1);
   localparam logic [AW-1:0] ALL1  = '1;
   localparam logic [LW:0]   LAST  = (LW+1)'(AW - 1);
   localparam logic [LW:0]   FULL  = (LW+1)'(AW);
   localparam logic [LW:0]   SHONE = (LW+1)'(1);

   logic [AW-1:0] w_bf;
   logic [LW:0]   w_sh;
   logic [AW-1:0] w_len;
   logic [AW-1:0] w_grp;
   logic [AW-1:0] w_j;
   logic [AW-1:0] w_k;

   // Groups are 2*len wide, so the group index is simply shifted into the upper bits of j.
   always_comb begin
      w_bf  = {1'b0, i_bf};
      w_sh  = {1'b0, i_layer};
      w_len = HALF >> i_layer;
      w_grp = w_bf >> (LAST - w_sh);
      w_j   = (w_grp << (FULL - w_sh)) | (w_bf & (w_len - ONE));
      w_k   = (ONE << i_layer) + w_grp;
`ifdef NTT_ADDR_GEN_INTT_EN
      if (i_inv) begin
         w_len = ONE << i_layer;
         w_grp = w_bf >> i_layer;
         w_j   = (w_grp << (w_sh + SHONE)) | (w_bf & (w_len - ONE));
         w_k   = (ALL1 >> i_layer) - w_grp;
      end
`endif
   end

   assign o_j  = w_j;
   assign o_jl = w_j + w_len;
   assign o_k  = w_k;

endmodule

// File: rtl/ntt_addr_gen.sv
// NTT control/address stage: walks all layers, drives the zeta ROM and presents aligned address pairs.
// Define NTT_ADDR_GEN_INTT_EN to add the inverse-transform ports i_inv and o_neg_zeta.
module ntt_addr_gen
   import ntt_pkg::*;
#(
   parameter int N      = 256,
   parameter int LAYERS = 8,
   parameter int ZW     = 8
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic                    i_stall,
`ifdef NTT_ADDR_GEN_INTT_EN
   input  logic                    i_inv,
   output logic                    o_neg_zeta,
`endif
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_zeta_en,
   output logic [ZW-1:0]           o_zeta_addr,
   output logic                    o_bf_valid,
   output logic [$clog2(N)-1:0]    o_addr_a,
   output logic [$clog2(N)-1:0]    o_addr_b,
   output logic [$clog2(LAYERS)-1:0] o_layer,
   output logic                    o_last_in_layer
);

   localparam int AW = $clog2(N);
   localparam int LW = $clog2(LAYERS);
   localparam logic [LW-1:0] LAST_L = LW'(LAYERS - 1);

   state_t        r_state;
   state_t        w_next;
   logic          w_issue;
   logic [LW-1:0] r_layer;
   logic [AW-2:0] r_bf;
   logic          w_last_bf;
   logic [AW-1:0] w_j;
   logic [AW-1:0] w_jl;
   logic [AW-1:0] w_k;

   logic          r_bf_valid;
   logic [AW-1:0] r_addr_a;
   logic [AW-1:0] r_addr_b;
   logic [LW-1:0] r_stage_layer;
   logic          r_last;

`ifdef NTT_ADDR_GEN_INTT_EN
   logic          r_inv;
   logic          r_neg;
`endif

   assign w_last_bf = (r_bf == '1);

   ntt_idx_calc #(.AW(AW)) u_idx (
      .i_layer (r_layer),
      .i_bf    (r_bf),
`ifdef NTT_ADDR_GEN_INTT_EN
      .i_inv   (r_inv),
`endif
      .o_j     (w_j),
      .o_jl    (w_jl),
      .o_k     (w_k)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   // An issue is one ROM read plus one stage load; stall suppresses both so nothing is lost.
   always_comb begin
      w_next      = r_state;
      w_issue     = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_zeta_en   = 1'b0;
      o_zeta_addr = '0;
      unique case (r_state)
         S_IDLE: begin
            if (i_start) w_next = S_RUN;
         end
         S_RUN: begin
            o_busy = 1'b1;
            if (!i_stall) begin
               w_issue     = 1'b1;
               o_zeta_en   = 1'b1;
               o_zeta_addr = ZW'(w_k);
               if (w_last_bf && r_layer == LAST_L) w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            o_busy = 1'b1;
            if (!i_stall) w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_layer <= '0;
         r_bf    <= '0;
`ifdef NTT_ADDR_GEN_INTT_EN
         r_inv   <= 1'b0;
`endif
      end else if (r_state == S_IDLE && i_start) begin
         r_layer <= '0;
         r_bf    <= '0;
`ifdef NTT_ADDR_GEN_INTT_EN
         r_inv   <= i_inv;
`endif
      end else if (w_issue) begin
         r_bf <= r_bf + 1'b1;
         if (w_last_bf) r_layer <= r_layer + 1'b1;
      end
   end

   // The stage mirrors the ROM's one-cycle latency so the address pair lines up with its zeta.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bf_valid    <= 1'b0;
         r_addr_a      <= '0;
         r_addr_b      <= '0;
         r_stage_layer <= '0;
         r_last        <= 1'b0;
`ifdef NTT_ADDR_GEN_INTT_EN
         r_neg         <= 1'b0;
`endif
      end else if (w_issue) begin
         r_bf_valid    <= 1'b1;
         r_addr_a      <= w_j;
         r_addr_b      <= w_jl;
         r_stage_layer <= r_layer;
         r_last        <= w_last_bf;
`ifdef NTT_ADDR_GEN_INTT_EN
         r_neg         <= r_inv;
`endif
      end else if (r_state == S_DRAIN && !i_stall) begin
         r_bf_valid <= 1'b0;
         r_last     <= 1'b0;
      end
   end

   assign o_bf_valid      = r_bf_valid;
   assign o_addr_a        = r_addr_a;
   assign o_addr_b        = r_addr_b;
   assign o_layer         = r_stage_layer;
   assign o_last_in_layer = r_last;
`ifdef NTT_ADDR_GEN_INTT_EN
   assign o_neg_zeta      = r_neg;
`endif

endmodule

// File: tb/tb_ntt_addr_gen.sv
// Scoreboard bench for ntt_addr_gen with a mock one-cycle zeta ROM.
// Inverse-mode checks are built only when NTT_ADDR_GEN_INTT_EN is defined.
module tb_ntt_addr_gen;

   typedef struct {
      int a;
      int b;
      int l;
      bit last;
      int k;
      bit neg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start;
   logic        stall;
   logic        busy;
   logic        done;
   logic        zetaEn;
   logic [7:0]  zetaAddr;
   logic        bfValid;
   logic [7:0]  addrA;
   logic [7:0]  addrB;
   logic [2:0]  layer;
   logic        lastInLayer;
   logic [15:0] romDo;
`ifdef NTT_ADDR_GEN_INTT_EN
   logic        inv;
   logic        negZeta;
`endif

   exp_t sbQ[$];
   exp_t popped;
   int   checks   = 0;
   int   errors   = 0;
   int   consumed = 0;
   bit   runInv   = 1'b0;

   always #5 clk = ~clk;

   ntt_addr_gen dut (
      .i_clk           (clk),
      .i_rst_n         (rstN),
      .i_start         (start),
      .i_stall         (stall),
`ifdef NTT_ADDR_GEN_INTT_EN
      .i_inv           (inv),
      .o_neg_zeta      (negZeta),
`endif
      .o_busy          (busy),
      .o_done          (done),
      .o_zeta_en       (zetaEn),
      .o_zeta_addr     (zetaAddr),
      .o_bf_valid      (bfValid),
      .o_addr_a        (addrA),
      .o_addr_b        (addrB),
      .o_layer         (layer),
      .o_last_in_layer (lastInLayer)
   );

   // Mock zeta ROM: the word carries its own index so alignment errors show up directly.
   function automatic logic [15:0] romVal(input logic [7:0] k);
      return {k, k ^ 8'hA5};
   endfunction

   always_ff @(posedge clk) begin
      if (zetaEn) romDo <= romVal(zetaAddr);
   end

   // Reference model written from the butterfly definition with plain integer arithmetic.
   function automatic exp_t model(input int l, input int b, input bit iv);
      exp_t e;
      int   len;
      int   grp;
      if (!iv) begin
         len = 128 / (1 << l);
         grp = b / len;
         e.k = (1 << l) + grp;
      end else begin
         len = 1 << l;
         grp = b / len;
         e.k = 256 / len - 1 - grp;
      end
      e.a    = grp * 2 * len + b % len;
      e.b    = e.a + len;
      e.l    = l;
      e.last = (b == 127);
      e.neg  = iv;
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic spotCheck(input string tag, input int a, input int b, input int l, input int k, input int last);
      checkOutput({tag, ".addrA"}, 32'(addrA), a);
      checkOutput({tag, ".addrB"}, 32'(addrB), b);
      checkOutput({tag, ".layer"}, 32'(layer), l);
      checkOutput({tag, ".k"}, 32'(romDo[15:8]), k);
      checkOutput({tag, ".last"}, 32'(lastInLayer), last);
   endtask

   // Monitor: a butterfly is consumed on a cycle with bf_valid high and stall low.
   always @(negedge clk) begin
      if (rstN === 1'b1 && bfValid === 1'b1 && stall === 1'b0) begin
         if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sbUnderflow: unexpected butterfly a=%0d b=%0d", addrA, addrB);
         end else begin
            popped = sbQ.pop_front();
            checkOutput("sb.addrA", 32'(addrA), popped.a);
            checkOutput("sb.addrB", 32'(addrB), popped.b);
            checkOutput("sb.layer", 32'(layer), popped.l);
            checkOutput("sb.last", 32'(lastInLayer), 32'(popped.last));
            checkOutput("sb.romDo", 32'(romDo), 32'(romVal(8'(popped.k))));
`ifdef NTT_ADDR_GEN_INTT_EN
            checkOutput("sb.negZeta", 32'(negZeta), 32'(popped.neg));
`endif
         end
         if (!runInv) begin
            case (consumed)
               0:    spotCheck("fwdFirst", 0, 128, 0, 1, 0);
               389:  spotCheck("fwdL3B5", 5, 21, 3, 8, 0);
               511:  spotCheck("fwdL3B127", 239, 255, 3, 15, 1);
               549:  spotCheck("fwdL4B37", 69, 77, 4, 20, 0);
               1023: spotCheck("fwdLast", 254, 255, 7, 255, 1);
               default: ;
            endcase
         end else begin
            case (consumed)
               0:    spotCheck("invFirst", 0, 1, 0, 255, 0);
               1023: spotCheck("invLast", 127, 255, 7, 1, 1);
               default: ;
            endcase
         end
         consumed++;
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".busy"}, 32'(busy), 0);
      checkOutput({tag, ".done"}, 32'(done), 0);
      checkOutput({tag, ".zetaEn"}, 32'(zetaEn), 0);
      checkOutput({tag, ".zetaAddr"}, 32'(zetaAddr), 0);
      checkOutput({tag, ".bfValid"}, 32'(bfValid), 0);
      checkOutput({tag, ".addrA"}, 32'(addrA), 0);
      checkOutput({tag, ".addrB"}, 32'(addrB), 0);
      checkOutput({tag, ".layer"}, 32'(layer), 0);
      checkOutput({tag, ".last"}, 32'(lastInLayer), 0);
   endtask

   // One transform: optional start poke while busy, optional 3-cycle stall, optional reset abort.
   task automatic applyStimulus(input bit iv, input int stallAt, input int abortAt, input bit pokeStart);
      int   cyc;
      int   validCycles;
      bit   prevValid;
      bit   sawDone;
      bit   stalled;
      logic [7:0]  snapA, snapB;
      logic [2:0]  snapL;
      logic        snapLast;
      logic [15:0] snapRom;
      exp_t first;

      sbQ.delete();
      for (int l = 0; l < 8; l++)
         for (int b = 0; b < 128; b++)
            sbQ.push_back(model(l, b, iv));
      first = model(0, 0, iv);
      consumed = 0;
      runInv = iv;

      @(posedge clk); #1;
      start = 1'b1;
`ifdef NTT_ADDR_GEN_INTT_EN
      inv = iv;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("cyc1.busy", 32'(busy), 1);
      checkOutput("cyc1.bfValid", 32'(bfValid), 0);
      checkOutput("cyc1.zetaEn", 32'(zetaEn), 1);
      checkOutput("cyc1.zetaAddr", 32'(zetaAddr), first.k);
      @(posedge clk); #1;
      checkOutput("cyc2.bfValid", 32'(bfValid), 1);

      validCycles = 0;
      prevValid   = 1'b0;
      sawDone     = 1'b0;
      stalled     = 1'b0;
      for (cyc = 0; cyc < 3000; cyc++) begin
         if (done === 1'b1) begin
            sawDone = 1'b1;
            break;
         end
         if (abortAt >= 0 && consumed == abortAt) begin
            rstN = 1'b0;
            #1;
            checkAllZero("abort");
            for (int i = 0; i < 3; i++) begin
               @(posedge clk); #1;
               checkOutput("abort.noDone", 32'(done), 0);
            end
            sbQ.delete();
            rstN = 1'b1;
            @(posedge clk); #1;
            checkAllZero("abortIdle");
            return;
         end
         start = (pokeStart && cyc == 100);
         if (bfValid === 1'b1) validCycles++;
         prevValid = bfValid;
         if (stallAt >= 0 && !stalled && consumed == stallAt && bfValid === 1'b1) begin
            stalled  = 1'b1;
            stall    = 1'b1;
            snapA    = addrA;
            snapB    = addrB;
            snapL    = layer;
            snapLast = lastInLayer;
            snapRom  = romDo;
            #1;
            checkOutput("stall.zetaEn", 32'(zetaEn), 0);
            for (int i = 0; i < 3; i++) begin
               @(posedge clk); #1;
               checkOutput("stall.bfValid", 32'(bfValid), 1);
               checkOutput("stall.addrA", 32'(addrA), 32'(snapA));
               checkOutput("stall.addrB", 32'(addrB), 32'(snapB));
               checkOutput("stall.layer", 32'(layer), 32'(snapL));
               checkOutput("stall.last", 32'(lastInLayer), 32'(snapLast));
               checkOutput("stall.romDo", 32'(romDo), 32'(snapRom));
               if (i < 2) checkOutput("stall.zetaEnHeld", 32'(zetaEn), 0);
            end
            stall = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;

      checkOutput("doneSeen", 32'(sawDone), 1);
      if (sawDone) begin
         checkOutput("done.busy", 32'(busy), 0);
         checkOutput("done.consumed", consumed, 1024);
         checkOutput("done.afterValid", 32'(prevValid), 1);
         checkOutput("done.bfValid", 32'(bfValid), 0);
         if (stallAt < 0) checkOutput("done.validCycles", validCycles, 1024);
         checkOutput("done.sbEmpty", sbQ.size(), 0);
         @(posedge clk); #1;
         checkOutput("done.onePulse", 32'(done), 0);
      end
   endtask

   initial begin
      rstN  = 1'b1;
      start = 1'b0;
      stall = 1'b0;
`ifdef NTT_ADDR_GEN_INTT_EN
      inv   = 1'b0;
`endif
      #1 rstN = 1'b0;
      #2;
      checkAllZero("reset");
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkAllZero("resetStart");
      start = 1'b0;
      rstN  = 1'b1;

      stall = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("idleStall.busy", 32'(busy), 0);
      checkOutput("idleStall.zetaEn", 32'(zetaEn), 0);
      stall = 1'b0;

      $display("[TB] forward run with start poked while busy");
      applyStimulus(1'b0, -1, -1, 1'b1);
      $display("[TB] forward run with 3-cycle stall in layer 2");
      applyStimulus(1'b0, 300, -1, 1'b0);
      $display("[TB] forward run aborted by reset at butterfly 500");
      applyStimulus(1'b0, -1, 500, 1'b0);
      $display("[TB] forward run after abort");
      applyStimulus(1'b0, -1, -1, 1'b0);
`ifdef NTT_ADDR_GEN_INTT_EN
      $display("[TB] inverse run");
      applyStimulus(1'b1, -1, -1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
